// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_frame_ctrl                                            |
// | Brief    : UART Tx frame sequencer/serializer with parity-calc handshake |
// |            Option macro UART_TX_STOP2_EN selects two stop bits.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_frame_ctrl #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] p_data,
   input  logic              data_valid,
   input  logic              par_en,
   input  logic              par_typ,
   input  logic              parity_result,
   output logic [DATA_W-1:0] par_data,
   output logic              par_load,
   output logic              par_typ_o,
   output logic              tx_out,
   output logic              busy
);

   localparam int                 C_BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [15:0]        C_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [C_BIT_W-1:0] C_BIT_LAST  = C_BIT_W'(DATA_W - 1);
`ifdef UART_TX_STOP2_EN
   localparam logic               C_STOP_LAST = 1'b1;
`else
   localparam logic               C_STOP_LAST = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [15:0]          r_baud_cnt;
   logic [C_BIT_W-1:0]   r_bit_cnt;
   logic                 r_stop_cnt;
   logic                 r_par_en;
   logic                 w_baud_tc;
   logic                 w_accept;

   always_comb begin
      w_baud_tc   = (r_baud_cnt == C_BAUD_LAST);
      w_accept    = (r_state == S_IDLE) && data_valid;
      w_state_nxt = r_state;
      tx_out      = 1'b1;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_START;
         end
         S_START: begin
            tx_out = 1'b0;
            if (w_baud_tc) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            tx_out = par_data[r_bit_cnt];
            if (w_baud_tc && (r_bit_cnt == C_BIT_LAST))
               w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            tx_out = parity_result;
            if (w_baud_tc) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            tx_out = 1'b1;
            if (w_baud_tc && (r_stop_cnt == C_STOP_LAST)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_par_en   <= 1'b0;
         par_data   <= '0;
         par_typ_o  <= 1'b0;
         par_load   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         par_load <= w_accept;
         if (w_accept) begin
            par_data  <= p_data;
            par_typ_o <= par_typ;
            r_par_en  <= par_en;
         end
         // Baud counter idles at zero so START always gets a full bit period.
         if ((r_state == S_IDLE) || w_baud_tc)
            r_baud_cnt <= '0;
         else
            r_baud_cnt <= r_baud_cnt + 16'd1;
         if ((r_state == S_DATA) && w_baud_tc)
            r_bit_cnt <= (r_bit_cnt == C_BIT_LAST) ? '0 : r_bit_cnt + C_BIT_W'(1);
         if ((r_state == S_STOP) && w_baud_tc)
            r_stop_cnt <= (r_stop_cnt == C_STOP_LAST) ? 1'b0 : 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_frame_ctrl                                         |
// | Brief    : Directed scoreboard bench for uart_tx_frame_ctrl (1 and 4     |
// |            clocks per bit), honours UART_TX_STOP2_EN.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_frame_ctrl;

`ifdef UART_TX_STOP2_EN
   localparam int C_NSTOP = 2;
`else
   localparam int C_NSTOP = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] p_data;
   logic       par_en, par_typ;
   logic       dv1, dv4;
   logic       pr1, pr4;
   logic [7:0] par_data1, par_data4;
   logic       par_load1, par_load4, par_typ_o1, par_typ_o4;
   logic       tx1, tx4, busy1, busy4;

   int         n_pass  = 0;
   int         n_total = 0;
   int         loads1  = 0;
   int         loads4  = 0;
   logic [1:0] exp_q[$];   // {busy, tx} per cycle

   always #5 clk = ~clk;

   uart_tx_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv1), .par_en(par_en),
      .par_typ(par_typ), .parity_result(pr1), .par_data(par_data1), .par_load(par_load1),
      .par_typ_o(par_typ_o1), .tx_out(tx1), .busy(busy1));

   uart_tx_frame_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv4), .par_en(par_en),
      .par_typ(par_typ), .parity_result(pr4), .par_data(par_data4), .par_load(par_load4),
      .par_typ_o(par_typ_o4), .tx_out(tx4), .busy(busy4));

   // Downstream parity calculator model: captures on load.
   initial begin
      pr1 = 1'b0;
      pr4 = 1'b0;
   end
   always @(posedge clk) begin
      if (par_load1) pr1 <= (^par_data1) ^ par_typ_o1;
      if (par_load4) pr4 <= (^par_data4) ^ par_typ_o4;
   end
   always @(negedge clk) begin
      loads1 += int'(par_load1);
      loads4 += int'(par_load4);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic push_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input int clks);
      for (int c = 0; c < clks; c++) exp_q.push_back(2'b10);
      for (int b = 0; b < 8; b++)
         for (int c = 0; c < clks; c++) exp_q.push_back({1'b1, d[b]});
      if (pen)
         for (int c = 0; c < clks; c++) exp_q.push_back({1'b1, (^d) ^ ptyp});
      for (int c = 0; c < clks * C_NSTOP; c++) exp_q.push_back(2'b11);
   endtask

   task automatic push_idle();
      exp_q.push_back(2'b01);
   endtask

   // Compare n cycles against the scoreboard, sampling on the falling edge.
   task automatic drain(input int sel, input int n);
      logic [1:0] e;
      for (int k = 0; k < n; k++) begin
         if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("tx_out", (sel == 4) ? tx4 : tx1, e[0]);
            chk("busy", (sel == 4) ? busy4 : busy1, e[1]);
         end
         @(negedge clk);
      end
   endtask

   int l0;
   int flen;

   initial begin
      rst = 1'b1; dv1 = 1'b0; dv4 = 1'b0;
      p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx1, 1'b1);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_load", par_load1, 1'b0);
      chk("rst_pdata", par_data1, 8'h00);
      chk("rst_ptyp", par_typ_o1, 1'b0);
      chk("rst_tx4", tx4, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // Frame A5, even parity, then odd parity
      for (int t = 0; t < 2; t++) begin
         l0 = loads1;
         p_data = 8'hA5; par_en = 1'b1; par_typ = 1'(t); dv1 = 1'b1;
         push_frame(8'hA5, 1'b1, 1'(t), 1);
         push_idle();
         @(negedge clk);
         dv1 = 1'b0;
         drain(1, exp_q.size());
         chk("a5_loads", loads1 - l0, 1);
      end

      // Reset during DATA bit 3, with rst winning over data_valid
      p_data = 8'h5A; par_en = 1'b0; par_typ = 1'b0; dv1 = 1'b1;
      push_frame(8'h5A, 1'b0, 1'b0, 1);
      @(negedge clk);
      dv1 = 1'b0;
      drain(1, 4);
      chk("bit3_tx", tx1, 1'b1);
      rst = 1'b1; dv1 = 1'b1;
      @(negedge clk);
      exp_q.delete();
      chk("abort_tx", tx1, 1'b1);
      chk("abort_busy", busy1, 1'b0);
      chk("abort_load", par_load1, 1'b0);
      chk("abort_pdata", par_data1, 8'h00);
      @(negedge clk);
      chk("rst_prio_busy", busy1, 1'b0);

      // Clean frame after reset: 01, no parity
      rst = 1'b0;
      l0 = loads1;
      p_data = 8'h01; par_en = 1'b0;
      push_frame(8'h01, 1'b0, 1'b0, 1);
      push_idle();
      @(negedge clk);
      dv1 = 1'b0;
      drain(1, exp_q.size());
      chk("p01_loads", loads1 - l0, 1);

      // FF at 4 clocks per bit
      l0 = loads4;
      p_data = 8'hFF; par_en = 1'b1; par_typ = 1'b0; dv4 = 1'b1;
      push_frame(8'hFF, 1'b1, 1'b0, 4);
      push_idle();
      chk("ff_len", exp_q.size(), (11 + C_NSTOP - 1) * 4 + 1);
      @(negedge clk);
      dv4 = 1'b0;
      drain(4, exp_q.size());
      chk("ff_loads", loads4 - l0, 1);

      // data_valid held through a frame: new byte ignored until one IDLE cycle
      l0 = loads1;
      flen = 10 + C_NSTOP;
      p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b1; dv1 = 1'b1;
      push_frame(8'h3C, 1'b1, 1'b1, 1);
      push_idle();
      push_frame(8'hC3, 1'b1, 1'b0, 1);
      push_idle();
      @(negedge clk);
      p_data = 8'hC3; par_typ = 1'b0;
      drain(1, flen + 1);
      dv1 = 1'b0;
      drain(1, exp_q.size());
      chk("held_loads", loads1 - l0, 2);
      chk("hold_pdata", par_data1, 8'hC3);
      chk("hold_ptyp", par_typ_o1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
